// File: rtl/stream_demux.sv
// Registered 1-to-N stream demultiplexer with one-entry holding register per channel.
// Optional broadcast input enabled by defining STREAM_DEMUX_BCAST_EN.
module stream_demux #(
  parameter int WIDTH = 4,
  parameter int CHANNELS = 4,
  localparam int SEL_W = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic                      in_valid,
  output logic                      in_ready,
`ifdef STREAM_DEMUX_BCAST_EN
  input  logic                      in_bcast,
`endif
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic                      bad_sel,
  input  logic                      clr_err
);

  logic [WIDTH-1:0]    data_p0 [CHANNELS];
  logic [CHANNELS-1:0] vld_p0;
  logic [CHANNELS-1:0] slot_free;
  logic [CHANNELS-1:0] load;
  logic                sel_ok;
  logic                sel_free;
  logic                accept;
  logic                bcast;

`ifdef STREAM_DEMUX_BCAST_EN
  assign bcast = in_bcast;
`else
  assign bcast = 1'b0;
`endif

  // A slot can take a word if empty or being drained in this same cycle.
  assign slot_free = ~vld_p0 | out_ready;

  always_comb begin
    sel_ok   = 32'(in_sel) < 32'(CHANNELS);
    sel_free = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (32'(in_sel) == 32'(i)) sel_free = slot_free[i];
    end
  end

  // Out-of-range selects are always accepted so the producer is never wedged.
  assign in_ready = bcast ? &slot_free : (~sel_ok | sel_free);
  assign accept   = in_valid & in_ready;

  always_comb begin
    load = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      load[i] = accept & (bcast | (sel_ok & (32'(in_sel) == 32'(i))));
    end
  end

  // Stage p0: holding registers; a refill takes priority over a drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= '0;
      for (int i = 0; i < CHANNELS; i++) data_p0[i] <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (load[i]) begin
          data_p0[i] <= in_data;
          vld_p0[i]  <= 1'b1;
        end else if (vld_p0[i] && out_ready[i]) begin
          data_p0[i] <= '0;
          vld_p0[i]  <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bad_sel <= 1'b0;
    end else if (accept && !bcast && !sel_ok) begin
      bad_sel <= 1'b1;
    end else if (clr_err) begin
      bad_sel <= 1'b0;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_out
    assign out_data[g*WIDTH +: WIDTH] = data_p0[g];
  end

  assign out_valid = vld_p0;

endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux: a 4-channel instance for routing/backpressure
// and a 3-channel instance for out-of-range selects.
module tb_stream_demux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [3:0]  d4 = '0;
  logic [1:0]  s4 = '0;
  logic        v4 = 1'b0;
  logic        rdy4;
  logic [15:0] od4;
  logic [3:0]  ov4;
  logic [3:0]  or4 = '0;
  logic        bad4;
  logic        clr4 = 1'b0;
`ifdef STREAM_DEMUX_BCAST_EN
  logic        bc4 = 1'b0;
`endif

  logic [3:0]  d3 = '0;
  logic [1:0]  s3 = '0;
  logic        v3 = 1'b0;
  logic        rdy3;
  logic [11:0] od3;
  logic [2:0]  ov3;
  logic [2:0]  or3 = '0;
  logic        bad3;
  logic        clr3 = 1'b0;
`ifdef STREAM_DEMUX_BCAST_EN
  logic        bc3 = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_demux #(.WIDTH(4), .CHANNELS(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_data(d4), .in_sel(s4), .in_valid(v4),
    .in_ready(rdy4),
`ifdef STREAM_DEMUX_BCAST_EN
    .in_bcast(bc4),
`endif
    .out_data(od4), .out_valid(ov4), .out_ready(or4),
    .bad_sel(bad4), .clr_err(clr4)
  );

  stream_demux #(.WIDTH(4), .CHANNELS(3)) u3 (
    .clk(clk), .rst_n(rst_n), .in_data(d3), .in_sel(s3), .in_valid(v3),
    .in_ready(rdy3),
`ifdef STREAM_DEMUX_BCAST_EN
    .in_bcast(bc3),
`endif
    .out_data(od3), .out_valid(ov3), .out_ready(or3),
    .bad_sel(bad3), .clr_err(clr3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset and idle
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    chk("rst_valid", 32'(ov4), 'h0);
    chk("rst_data", 32'(od4), 'h0);
    chk("rst_bad", 32'(bad4), 'h0);

    // load channel 2 with A, then async reset mid-cycle
    tick();
    d4 = 4'hA; s4 = 2'd2; v4 = 1'b1; or4 = 4'b0000;
    tick();
    v4 = 1'b0;
    chk("hold2_valid", 32'(ov4), 'h4);
    chk("hold2_data", 32'(od4), 'h0A00);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(ov4), 'h0);
    chk("async_rst_data", 32'(od4), 'h0);
    #1 rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 32'(rdy4), 'h1);

    // basic route
    tick();
    or4 = 4'b1111; d4 = 4'h5; s4 = 2'd1; v4 = 1'b1;
    tick();
    v4 = 1'b0;
    chk("route_valid", 32'(ov4), 'h2);
    chk("route_data", 32'(od4), 'h0050);
    tick();
    chk("drain_valid", 32'(ov4), 'h0);
    chk("drain_data", 32'(od4), 'h0);

    // backpressure and independence
    or4 = 4'b0111; d4 = 4'h7; s4 = 2'd3; v4 = 1'b1;
    #1 chk("bpA_ready", 32'(rdy4), 'h1);
    tick();
    chk("bpA_valid", 32'(ov4), 'h8);
    chk("bpA_data", 32'(od4), 'h7000);
    d4 = 4'h9; s4 = 2'd3;
    #1 chk("bpB_ready", 32'(rdy4), 'h0);
    tick();
    chk("bpB_valid", 32'(ov4), 'h8);
    chk("bpB_data", 32'(od4), 'h7000);
    d4 = 4'h2; s4 = 2'd0;
    #1 chk("bpC_ready", 32'(rdy4), 'h1);
    tick();
    v4 = 1'b0;
    chk("bpC_valid", 32'(ov4), 'h9);
    chk("bpC_data", 32'(od4), 'h7002);
    tick();
    chk("bp_ch0_drained", 32'(ov4), 'h8);
    chk("bp_ch3_kept", 32'(od4), 'h7000);
    or4 = 4'b1111;
    tick();
    chk("bp_all_empty", 32'(ov4), 'h0);

    // drain and refill on channel 0
    d4 = 4'h3; s4 = 2'd0; v4 = 1'b1;
    tick();
    chk("dr_first", 32'(od4), 'h0003);
    d4 = 4'hC;
    #1 chk("dr_ready", 32'(rdy4), 'h1);
    tick();
    chk("dr_valid", 32'(ov4), 'h1);
    chk("dr_data", 32'(od4), 'h000C);
    for (int k = 0; k < 8; k++) begin
      d4 = 4'(k);
      tick();
      chk($sformatf("b2b_%0d", k), {27'd0, ov4[0], od4[3:0]}, 32'h10 | 32'(k));
    end
    v4 = 1'b0;
    tick();
    chk("b2b_end", 32'(ov4), 'h0);

    // out-of-range select on the 3-channel instance
    or3 = 3'b000; d3 = 4'hF; s3 = 2'd3; v3 = 1'b1;
    #1 chk("bad_ready", 32'(rdy3), 'h1);
    tick();
    v3 = 1'b0;
    chk("bad_no_valid", 32'(ov3), 'h0);
    chk("bad_no_data", 32'(od3), 'h0);
    chk("bad_set", 32'(bad3), 'h1);
    chk("bad_other_inst", 32'(bad4), 'h0);
    tick();
    chk("bad_sticky", 32'(bad3), 'h1);
    clr3 = 1'b1;
    tick();
    clr3 = 1'b0;
    chk("bad_cleared", 32'(bad3), 'h0);
    v3 = 1'b1; clr3 = 1'b1;
    tick();
    v3 = 1'b0; clr3 = 1'b0;
    chk("bad_set_wins", 32'(bad3), 'h1);
    s3 = 2'd2; d3 = 4'h4; v3 = 1'b1;
    tick();
    v3 = 1'b0;
    chk("ch3inst_route", 32'(od3), 'h400);
    chk("ch3inst_valid", 32'(ov3), 'h4);

`ifdef STREAM_DEMUX_BCAST_EN
    // broadcast blocked by one stalled full channel
    or4 = 4'b1011; d4 = 4'h1; s4 = 2'd2; v4 = 1'b1;
    tick();
    chk("bc_pre", 32'(ov4), 'h4);
    bc4 = 1'b1; d4 = 4'h6; s4 = 2'd0;
    #1 chk("bc_blocked", 32'(rdy4), 'h0);
    tick();
    chk("bc_hold_valid", 32'(ov4), 'h4);
    chk("bc_hold_data", 32'(od4), 'h0100);
    or4 = 4'b1111;
    #1 chk("bc_ready", 32'(rdy4), 'h1);
    tick();
    bc4 = 1'b0; v4 = 1'b0;
    chk("bc_valid", 32'(ov4), 'hF);
    chk("bc_data", 32'(od4), 'h6666);
    chk("bc_no_bad", 32'(bad4), 'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
